vga_timing_out: RTL and testbench
=================================

Name: vga_timing_out

Overview:
- Generates 640x480@60 Hz VGA timing from the 25.175 MHz pixel clock.
- Publishes pixel coordinates to the upstream renderer.
- Re-aligns sync/blank to the renderer's fixed pipeline latency.
- Packs the returned 6-bit colour plus syncs onto the TinyVGA uo_out pin order. It is the last stage before the top-level dedicated outputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- PIX_LAT, 2, cycles from x/y presented to rgb_in valid (renderer latency); range 0..7

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- rgb_in  in  6  colour from renderer {R1,R0,G1,G0,B1,B0}, valid PIX_LAT cycles after matching x/y
- x  out  10  current horizontal count 0..799 (combinational from counter)
- y  out  10  current vertical count 0..524
- display_on  out  1  high when x<640 and y<480 (undelayed)
- line_start  out  1  one-cycle pulse when x==0
- frame_start  out  1  one-cycle pulse when x==0 and y==0
- frame_count  out  8  frames completed, wraps 255->0
- uo_out  out  8  [7]=hsync, [3]=vsync, [0]=R1, [4]=R0, [1]=G1, [5]=G0, [2]=B1, [6]=B0

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Counters:
  - h counts 0..H_TOTAL-1 (800), then wraps to 0.
  - v increments only on h wrap and counts 0..V_TOTAL-1 (525), then wraps to 0.
  - frame_count increments on the cycle v and h both wrap to 0.
- Sync generation (both syncs active-low):
  - hsync_raw low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 656..751.
  - vsync_raw low for v in 490..491, for the full line duration.
  - de_raw = display_on.
- Alignment: {hsync_raw, vsync_raw, de_raw} pass through a PIX_LAT-deep shift register. With PIX_LAT=0 the path is direct.
- Output register: uo_out is registered every cycle.
  - Colour bits = rgb_in when delayed de is high, else 0.
  - Sync bits = delayed syncs.
  - Total latency from x/y to pins = PIX_LAT+1 cycles.
- Reset (rst_n low at a clk edge):
  - h, v, frame_count = 0.
  - Delay-line sync stages = 1, de stages = 0.
  - uo_out = 8'h88 (syncs inactive, colour black).
  - The combinational outputs then reflect h=v=0: display_on=1, line_start=1, frame_start=1.
- Reset mid-frame: the same values apply on the next edge, and timing restarts at (0,0). No partial-line recovery is attempted.
- Wrap boundary: on h=799, v=524 the next cycle shows h=0, v=0, frame_start=1, frame_count+1 in the same cycle.
- Widths:
  - Counters are 10 bits.
  - Porch sums are computed as localparams.
  - Parameters must give H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024; elaboration error otherwise.
- No back-pressure: rgb_in is sampled unconditionally. The renderer is responsible for meeting PIX_LAT exactly.

Decomposition:
- Shared package vga_pkg:
  - default 640x480 timing constants (H_*/V_*, H_TOTAL=800, V_TOTAL=525)
  - TinyVGA bit-index constants for uo_out
  - packed typedef rgb6_t {r[1:0], g[1:0], b[1:0]}
- One natural sub-module: vga_sync_delay, a parameterised N-stage shift register for {hsync, vsync, de} with reset value {1,1,0}.
- Counters and output packing stay in the top of this block.

Test Plan:
- Reset: hold rst_n low 3 cycles.
  - uo_out == 8'h88, x==0, y==0, frame_start==1.
  - After release, x increments by 1 per cycle.
- Hsync (PIX_LAT=2):
  - uo_out[7] first falls 659 cycles after reset release and stays low 96 cycles.
  - Period is 800 cycles.
- Vsync:
  - uo_out[3] falls at cycle 490*800+3 after release, low for exactly 1600 cycles.
  - Next fall is 420000 cycles later; frame_count reads 1 at cycle 420000.
- Blanking:
  - Drive rgb_in=6'h3F constantly.
  - uo_out colour bits are 6'h3F-mapped (uo_out & 8'h77 == 8'h77) only for 640 consecutive cycles per visible line, otherwise 0.
  - Colour bits are 0 for all 45 blank lines.
- Pin mapping: in active area with syncs high:
  - rgb_in=6'b100000 -> uo_out==8'h89.
  - rgb_in=6'b010000 -> uo_out==8'h98.
  - rgb_in=6'b000001 -> uo_out==8'hC8.
- Reset mid-frame: assert rst_n low at x=300, y=200 for 1 cycle.
  - Next cycle x==0, y==0, uo_out==8'h88.
  - The subsequent hsync fall again lands at cycle 659.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, TinyVGA pin indices and colour/sync types.
package vga_pkg;

    // Default 640x480@60 timing (pixel clock 25.175 MHz)
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // TinyVGA uo_out bit positions
    localparam logic [2:0] UO_R1    = 3'd0;
    localparam logic [2:0] UO_G1    = 3'd1;
    localparam logic [2:0] UO_B1    = 3'd2;
    localparam logic [2:0] UO_VSYNC = 3'd3;
    localparam logic [2:0] UO_R0    = 3'd4;
    localparam logic [2:0] UO_G0    = 3'd5;
    localparam logic [2:0] UO_B0    = 3'd6;
    localparam logic [2:0] UO_HSYNC = 3'd7;

    // Renderer colour word {R1,R0,G1,G0,B1,B0}
    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb6_t;

    // Sync/blank bundle carried through the latency-matching delay line
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    // Idle value: both syncs inactive (high), display disabled
    localparam logic [2:0] SYNC_IDLE = 3'b110;

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage shift register for {hsync, vsync, de}; N=0 is a straight wire.
module vga_sync_delay #(
    parameter int N = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sync_in,
    output logic [2:0] sync_out
);
    import vga_pkg::*;

    if (N == 0) begin : g_direct
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, rst_n};
        assign sync_out    = sync_in;
    end else begin : g_pipe
        logic [2:0] stage_q [N];
        logic [2:0] stage_d [N];

        // Each stage takes its predecessor; stage 0 takes the raw bus
        always_comb begin
            stage_d[0] = sync_in;
            for (int i = 1; i < N; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        // Shift every cycle; reset parks the line in the idle (syncs high) state
        always_ff @(posedge clk) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= (!rst_n) ? SYNC_IDLE : stage_d[i];
            end
        end

        assign sync_out = stage_q[N-1];
    end

endmodule

// File: rtl/vga_timing_out.sv
// VGA timing generator with renderer-latency alignment and TinyVGA pin packing.
module vga_timing_out #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int PIX_LAT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] rgb_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic [7:0] uo_out
);
    import vga_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // 10-bit counters cannot represent longer frames
    if (H_TOT > 1024) begin : g_bad_h_total
        $error("vga_timing_out: horizontal total exceeds 1024");
    end
    if (V_TOT > 1024) begin : g_bad_v_total
        $error("vga_timing_out: vertical total exceeds 1024");
    end
    if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_bad_lat
        $error("vga_timing_out: PIX_LAT must be within 0..7");
    end

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic [7:0] frame_q, frame_d;
    logic [7:0] uo_q, uo_d;
    logic       h_wrap, v_wrap;
    sync_t      sync_raw;
    sync_t      sync_dly;
    rgb6_t      rgb;

    // Next-state for the pixel, line and frame counters
    always_comb begin
        h_wrap  = (h_q == H_LAST);
        v_wrap  = (v_q == V_LAST);
        h_d     = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d     = v_q;
        frame_d = frame_q;
        if (h_wrap) begin
            v_d = v_wrap ? 10'd0 : v_q + 10'd1;
            if (v_wrap) begin
                frame_d = frame_q + 8'd1;
            end
        end
    end

    // Raw (undelayed) active-low syncs and display enable from the counters
    always_comb begin
        sync_raw.hsync = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
        sync_raw.vsync = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
        sync_raw.de    = (h_q < H_VIS) && (v_q < V_VIS);
    end

    vga_sync_delay #(
        .N (PIX_LAT)
    ) u_sync_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_in  (sync_raw),
        .sync_out (sync_dly)
    );

    // Pack delayed syncs and blanked colour onto the TinyVGA pin order
    always_comb begin
        rgb  = rgb6_t'(rgb_in);
        uo_d = 8'h00;
        uo_d[UO_HSYNC] = sync_dly.hsync;
        uo_d[UO_VSYNC] = sync_dly.vsync;
        if (sync_dly.de) begin
            uo_d[UO_R1] = rgb.r[1];
            uo_d[UO_R0] = rgb.r[0];
            uo_d[UO_G1] = rgb.g[1];
            uo_d[UO_G0] = rgb.g[0];
            uo_d[UO_B1] = rgb.b[1];
            uo_d[UO_B0] = rgb.b[0];
        end
    end

    // State registers; reset restarts timing at (0,0) with idle pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            frame_q <= 8'd0;
            uo_q    <= 8'h88;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            uo_q    <= uo_d;
        end
    end

    assign x           = h_q;
    assign y           = v_q;
    assign display_on  = sync_raw.de;
    assign line_start  = (h_q == 10'd0);
    assign frame_start = (h_q == 10'd0) && (v_q == 10'd0);
    assign frame_count = frame_q;
    assign uo_out      = uo_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: arithmetic frame model checked every cycle plus
// directed literal checks on sync edges, blanking, pin mapping and reset.
// Vertical timing is shortened (60 lines) so a full frame fits a short run.
`timescale 1ns/1ps
module tb_vga_timing_out;

    localparam int HT = 800;            // 640 + 16 + 96 + 48
    localparam int VA = 48;
    localparam int VF = 4;
    localparam int VS = 2;
    localparam int VB = 6;
    localparam int VT = VA + VF + VS + VB; // 60
    localparam int FRAME = HT * VT;       // 48000

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] rgb_in = 6'h00;
    logic [9:0] x, y;
    logic       display_on, line_start, frame_start;
    logic [7:0] frame_count, uo_out;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;          // clock edges since the last reset edge
    logic [5:0] rgb_s = 6'h00; // rgb_in as sampled by the last edge
    bit   chk_en = 1'b1;

    vga_timing_out #(
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB),
        .PIX_LAT  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rgb_in      (rgb_in),
        .x           (x),
        .y           (y),
        .display_on  (display_on),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count),
        .uo_out      (uo_out)
    );

    always #20 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
        rgb_s <= rgb_in;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected pins: raw timing of the pixel 3 cycles ago, colour from the last sample
    function automatic logic [7:0] model_uo(input int c, input logic [5:0] rgb);
        int t, h, v;
        logic [7:0] u;
        if (c < 3) return 8'h88;
        t = c - 3;
        h = t % HT;
        v = (t / HT) % VT;
        u = 8'h00;
        u[7] = !(h >= 656 && h <= 751);
        u[3] = !(v >= VA + VF && v < VA + VF + VS);
        if (h < 640 && v < VA) begin
            u[0] = rgb[5]; u[4] = rgb[4];
            u[1] = rgb[3]; u[5] = rgb[2];
            u[2] = rgb[1]; u[6] = rgb[0];
        end
        return u;
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int h, v, f;
            h = cyc % HT;
            v = (cyc / HT) % VT;
            f = (cyc / FRAME) % 256;
            check("x", int'(x), h);
            check("y", int'(y), v);
            check("flags", int'({display_on, line_start, frame_start}),
                  int'({(h < 640 && v < VA), (h == 0), (h == 0 && v == 0)}));
            check("frame_count", int'(frame_count), f);
            check("uo_out", int'(uo_out), int'(model_uo(cyc, rgb_s)));
        end
    end

    task automatic wait_level(input int b, input logic lvl, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (uo_out[b] == lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int t_fall, t_rise, on_cnt, run, max_run, blank_on, vs_fall, vs_rise;
        int fc_at, x_at, y_at;
        bit vs_seen_low;

        // Reset held for 3 edges
        rst_n = 1'b0;
        rgb_in = 6'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_uo", int'(uo_out), 'h88);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_frame_start", int'(frame_start), 1);
        rst_n = 1'b1;
        rgb_in = 6'h3F;

        @(negedge clk);
        check("x_step1", int'(x), 1);
        @(negedge clk);
        check("x_step2", int'(x), 2);

        // Hsync: fall at 659, low 96 cycles, period 800
        wait_level(7, 1'b0, 2000, ok);
        check("hs_fall_seen", int'(ok), 1);
        t_fall = cyc;
        check("hs_fall_cycle", t_fall, 659);
        wait_level(7, 1'b1, 2000, ok);
        check("hs_rise_seen", int'(ok), 1);
        check("hs_low_len", cyc - t_fall, 96);
        wait_level(7, 1'b0, 2000, ok);
        check("hs_period", cyc - t_fall, 800);

        // One visible line: colour on for exactly 640 consecutive cycles
        for (int i = 0; i < 2000 && cyc < 1599; i++) @(negedge clk);
        on_cnt = 0; run = 0; max_run = 0;
        repeat (800) begin
            @(negedge clk);
            if ((uo_out & 8'h77) == 8'h77) begin
                on_cnt++; run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        check("line_on_count", on_cnt, 640);
        check("line_on_run", max_run, 640);

        // Vertical blank, vsync and frame wrap
        blank_on = 0; vs_fall = -1; vs_rise = -1; vs_seen_low = 1'b0;
        fc_at = -1; x_at = -1; y_at = -1;
        for (int i = 0; i < 60000 && cyc < 48002; i++) begin
            @(negedge clk);
            if (cyc >= VA * HT + 3 && (uo_out & 8'h77) != 8'h00) blank_on++;
            if (!vs_seen_low && uo_out[3] == 1'b0) begin
                vs_seen_low = 1'b1;
                vs_fall = cyc;
            end else if (vs_seen_low && vs_rise < 0 && uo_out[3] == 1'b1) begin
                vs_rise = cyc;
            end
            if (cyc == FRAME) begin
                fc_at = int'(frame_count);
                x_at = int'(x);
                y_at = int'(y);
            end
        end
        check("blank_colour", blank_on, 0);
        check("vs_fall_cycle", vs_fall, 52 * 800 + 3);
        check("vs_low_len", vs_rise - vs_fall, 1600);
        check("frame_count_1", fc_at, 1);
        check("wrap_xy", x_at + y_at, 0);

        // Pin mapping inside the active area (h=100, line 5 of frame 2)
        for (int i = 0; i < 10000 && cyc < FRAME + 5 * HT + 100; i++) @(negedge clk);
        rgb_in = 6'b100000;
        @(negedge clk);
        check("pin_R1", int'(uo_out), 'h89);
        rgb_in = 6'b010000;
        @(negedge clk);
        check("pin_R0", int'(uo_out), 'h98);
        rgb_in = 6'b000001;
        @(negedge clk);
        check("pin_B0", int'(uo_out), 'hC8);
        rgb_in = 6'h3F;

        // Reset mid-frame for one edge at (300, 20)
        ok = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (x == 10'd300 && y == 10'd20) begin
                ok = 1'b1;
                break;
            end
        end
        check("midrst_reached", int'(ok), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_x", int'(x), 0);
        check("midrst_y", int'(y), 0);
        check("midrst_uo", int'(uo_out), 'h88);
        rst_n = 1'b1;
        wait_level(7, 1'b0, 2000, ok);
        check("midrst_hs_seen", int'(ok), 1);
        check("midrst_hs_fall", cyc, 659);

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
